// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the universal shift register.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_SHL  = 2'd1,
        MODE_SHR  = 2'd2,
        MODE_LOAD = 2'd3
    } shift_mode_t;

    // Counter must represent 0..width so the wrap point is observable in width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_reg_universal_frame_counter.sv
// Frame counter: counts shifts, wraps at WIDTH and pulses done for one cycle on the wrap.
module shift_frame_counter
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        inc,
    input  logic                        clr,
    output logic [cnt_width(WIDTH)-1:0] cnt,
    output logic                        done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clr) begin
                cnt <= '0;
            end else if (inc) begin
                if (cnt == LAST) begin
                    cnt  <= '0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/shift_reg_universal.sv
// Universal shift register: hold / shift-left / shift-right / parallel load with frame pulse.
// Optional macro SHIFT_REG_ROTATE_EN adds a `rotate` input that recirculates the end bits.
module shift_reg_universal
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [1:0]                  mode,
    input  logic                        sdi_r,
    input  logic                        sdi_l,
`ifdef SHIFT_REG_ROTATE_EN
    input  logic                        rotate,
`endif
    input  logic [WIDTH-1:0]            pdi,
    output logic [WIDTH-1:0]            pdo,
    output logic                        sdo_msb,
    output logic                        sdo_lsb,
    output logic [cnt_width(WIDTH)-1:0] shift_cnt,
    output logic                        frame_done
);

    shift_mode_t      mode_e;
    logic             rot;
    logic             shl_bit;
    logic             shr_bit;
    logic             is_shift;
    logic             is_load;
    logic [WIDTH-1:0] pdo_next;

    assign mode_e = shift_mode_t'(mode);

`ifdef SHIFT_REG_ROTATE_EN
    assign rot = rotate;
`else
    assign rot = 1'b0;
`endif

    assign shl_bit  = rot ? pdo[WIDTH-1] : sdi_r;
    assign shr_bit  = rot ? pdo[0]       : sdi_l;
    assign is_shift = en && (mode_e == MODE_SHL || mode_e == MODE_SHR);
    assign is_load  = en && (mode_e == MODE_LOAD);

    always_comb begin
        pdo_next = pdo;
        if (en) begin
            unique case (mode_e)
                MODE_SHL:  pdo_next = {pdo[WIDTH-2:0], shl_bit};
                MODE_SHR:  pdo_next = {shr_bit, pdo[WIDTH-1:1]};
                MODE_LOAD: pdo_next = pdi;
                default:   pdo_next = pdo;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pdo <= RESET_VAL;
        end else begin
            pdo <= pdo_next;
        end
    end

    assign sdo_msb = pdo[WIDTH-1];
    assign sdo_lsb = pdo[0];

    shift_frame_counter #(
        .WIDTH(WIDTH)
    ) u_frame_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (is_shift),
        .clr   (is_load),
        .cnt   (shift_cnt),
        .done  (frame_done)
    );

endmodule
